j_row_streamer: RTL



---
 rtl/j_row_streamer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/j_row_streamer.sv
// rtl/j_row_streamer.sv - walks a contiguous range of J-matrix rows, one row group per cycle
//
// Purpose: on a start pulse, issues group reads to a banked row memory (one-cycle latency)
// and presents each returned group with a per-lane valid mask and the matching sigma bits.
// Handles unaligned/partial first and last groups, arbiter holds and end-of-run signalling.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             run request, sampled only while idle
//   first_row         first row of the run (latched at start)
//   num_rows          number of rows in the run (latched at start)
//   sigma_vec         spin bits for all rows (latched at start)
//   hold              arbiter hold: no read may be issued this cycle
//   mem_rd_en         group read strobe
//   mem_rd_addr       group address (row >> log2(NUM_ROWS_PER_CLK))
//   mem_rd_data       group data, valid the cycle after mem_rd_en
//   j_rows            presented row group, invalid lanes zeroed
//   j_rows_valid      per-lane valid mask
//   sigma_bits        per-lane sigma bit, zero on invalid lanes
//   last              high with the final group of a run
//   busy              high while not idle
//   done              one-cycle end-of-run pulse
module j_row_streamer #(
  parameter int NUM_ROWS_PER_CLK = 4,
  parameter int VECTOR_SIZE      = 256,
  parameter int DATA_WIDTH       = 4,
  parameter int NUM_ROWS         = 256,
  parameter int ROW_W            = $clog2(NUM_ROWS + 1),
  parameter int GRP_W            = (NUM_ROWS / NUM_ROWS_PER_CLK > 1) ?
                                   $clog2(NUM_ROWS / NUM_ROWS_PER_CLK) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ROW_W-1:0]            first_row,
  input  logic [ROW_W-1:0]            num_rows,
  input  logic [NUM_ROWS-1:0]         sigma_vec,
  input  logic                        hold,
  output logic                        mem_rd_en,
  output logic [GRP_W-1:0]            mem_rd_addr,
  input  logic [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] mem_rd_data,
  output logic [NUM_ROWS_PER_CLK-1:0][VECTOR_SIZE-1:0][DATA_WIDTH-1:0] j_rows,
  output logic [NUM_ROWS_PER_CLK-1:0] j_rows_valid,
  output logic [NUM_ROWS_PER_CLK-1:0] sigma_bits,
  output logic                        last,
  output logic                        busy,
  output logic                        done
);

  localparam int LOG2N = $clog2(NUM_ROWS_PER_CLK);
  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Run context, captured at start
  logic [ROW_W-1:0]    first_q;
  logic [ROW_W-1:0]    end_q;
  logic [NUM_ROWS-1:0] sigma_q;
  logic [GRP_W-1:0]    grp;
  logic [GRP_W-1:0]    last_grp;

  // Empty runs never leave IDLE; this flag produces their done pulse
  logic empty_done;

  // Copy of the previous cycle's read, aligned with the returned data
  logic             d_valid;
  logic             d_last;
  logic [GRP_W-1:0] d_grp;

  // Start-time range computation; the sum is one bit wider so it cannot wrap
  logic [ROW_W:0]   row_sum;
  logic [ROW_W-1:0] end_calc;
  logic [ROW_W-1:0] end_m1;
  logic             run_empty;

  assign row_sum   = {1'b0, first_row} + {1'b0, num_rows};
  assign end_calc  = (row_sum > (ROW_W+1)'(NUM_ROWS)) ? ROW_W'(NUM_ROWS) : row_sum[ROW_W-1:0];
  assign end_m1    = end_calc - 1'b1;
  // Also covers first_row >= NUM_ROWS, since end_calc is clamped to NUM_ROWS
  assign run_empty = (end_calc <= first_row);

  logic rd_en;
  logic issue_last;
  logic start_run;
  logic start_empty;

  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    issue_last  = 1'b0;
    start_run   = 1'b0;
    start_empty = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (run_empty) begin
            start_empty = 1'b1;
          end else begin
            start_run = 1'b1;
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (grp == last_grp) begin
            issue_last = 1'b1;
            state_nxt  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= '0;
      end_q      <= '0;
      sigma_q    <= '0;
      grp        <= '0;
      last_grp   <= '0;
      empty_done <= 1'b0;
      d_valid    <= 1'b0;
      d_last     <= 1'b0;
      d_grp      <= '0;
    end else begin
      empty_done <= start_empty;
      d_valid    <= rd_en;
      d_last     <= issue_last;
      d_grp      <= grp;
      if (start_run) begin
        first_q  <= first_row;
        end_q    <= end_calc;
        sigma_q  <= sigma_vec;
        grp      <= GRP_W'(first_row >> LOG2N);
        last_grp <= GRP_W'(end_m1 >> LOG2N);
      end else if (rd_en) begin
        grp <= grp + 1'b1;
      end
    end
  end

  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = rd_en ? grp : '0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DRAIN) | empty_done;
  assign last        = d_last;

  // Lane masking: row index of each lane against the latched [first, end) window
  for (genvar l = 0; l < NUM_ROWS_PER_CLK; l++) begin : g_lane
    logic [ROW_W-1:0] row;
    logic             ok;

    assign row = (ROW_W'(d_grp) << LOG2N) + ROW_W'(l);
    assign ok  = d_valid & (row >= first_q) & (row < end_q);

    assign j_rows[l]       = ok ? mem_rd_data[l] : '0;
    assign j_rows_valid[l] = ok;
    // A valid row is always below NUM_ROWS, so the truncated index is exact
    assign sigma_bits[l]   = ok & sigma_q[row[IDX_W-1:0]];
  end

endmodule
